// File: rtl/led_mux_pkg.sv
// rtl/led_mux_pkg.sv - shared types, constants and helpers for the 7-seg scan multiplexer
package led_mux_pkg;

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_e;

    localparam int          MAX_DIGITS = 16;
    localparam logic [31:0] SEG_BLANK  = '1;

    // All-ones (nothing selected) digit-select word for n digits.
    function automatic logic [MAX_DIGITS-1:0] sel_none(input int n);
        logic [MAX_DIGITS-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) s[i] = 1'b1;
        end
        return s;
    endfunction

    // Lit cycles per slot; 64-bit product so wide spans or codes cannot overflow.
    function automatic logic [31:0] calc_on_len(input int unsigned span,
                                                input int unsigned bright,
                                                input int unsigned bright_w);
        longint unsigned prod;
        prod = longint'(span) * (longint'(bright) + 64'd1);
        return 32'(prod >> bright_w);
    endfunction

endpackage

// File: rtl/led_slot_timer.sv
// rtl/led_slot_timer.sv - per-digit slot counter with blank/on/off phase decode
module led_slot_timer
    import led_mux_pkg::*;
#(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BRIGHT_W-1:0] brightness_i,
    output logic                slot_start_o,
    output logic                slot_end_o,
    output logic [1:0]          phase_o
);

    localparam int          CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          ON_W  = CNT_W + 1;
    localparam int unsigned SPAN  = SCAN_DIV - BLANK_CYCLES;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ON_W-1:0]  on_len_q, on_len_d, on_len_cur, on_len_calc;
    phase_e           phase;

    assign on_len_calc  = ON_W'(calc_on_len(SPAN, 32'(brightness_i), BRIGHT_W));
    assign slot_start_o = (cnt_q == '0);
    assign slot_end_o   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    // The first slot cycle already uses the freshly computed length.
    assign on_len_cur   = slot_start_o ? on_len_calc : on_len_q;
    assign phase_o      = phase;

    always_comb begin
        cnt_d    = slot_end_o ? '0 : cnt_q + 1'b1;
        on_len_d = on_len_cur;
        if (32'(cnt_q) < 32'(BLANK_CYCLES)) begin
            phase = PH_BLANK;
        end else if (32'(cnt_q) < 32'(BLANK_CYCLES) + 32'(on_len_cur)) begin
            phase = PH_ON;
        end else begin
            phase = PH_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            on_len_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            on_len_q <= on_len_d;
        end
    end

endmodule

// File: rtl/led_mux_scan.sv
// rtl/led_mux_scan.sv - multiplexed 7-seg scanner; optional blinking via LED_MUX_SCAN_BLINK_EN
module led_mux_scan
    import led_mux_pkg::*;
#(
    parameter int  NUM_DIGITS   = 8,
    parameter int  SEG_W        = 8,
    parameter int  SCAN_DIV     = 1024,
    parameter int  BLANK_CYCLES = 16,
    parameter int  BRIGHT_W     = 4,
    parameter int  BLINK_FRAMES = 64,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [BRIGHT_W-1:0]         brightness,
`ifdef LED_MUX_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]       LEDSEL,
    output logic [SEG_W-1:0]            LEDOUT,
    output logic [IDX_W-1:0]            cur_digit,
    output logic                        frame_tick
);

    localparam logic [MAX_DIGITS-1:0] SEL_NONE_W = sel_none(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_NONE   = SEL_NONE_W[NUM_DIGITS-1:0];
    localparam logic [SEG_W-1:0]      SEG_OFF    = SEG_BLANK[SEG_W-1:0];

    if (SCAN_DIV <= BLANK_CYCLES || NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS
        || SEG_W > 32 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("led_mux_scan: invalid parameter set");
    end

    logic                  slot_start, slot_end;
    logic [1:0]            phase;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
    logic [SEG_W-1:0]      seg_q, seg_d, slot_byte;
    logic                  lit_q, lit_d, slot_lit, found, blink_hide;
    logic [NUM_DIGITS-1:0] ledsel_q, ledsel_d;
    logic [SEG_W-1:0]      ledout_q, ledout_d;
    logic                  tick_q, tick_d;

    led_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .brightness_i (brightness),
        .slot_start_o (slot_start),
        .slot_end_o   (slot_end),
        .phase_o      (phase)
    );

    // Next enabled digit searching upward with wrap; the current digit is tried last.
    always_comb begin
        idx_next = idx_q;
        found    = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            int cand;
            cand = int'(idx_q) + k;
            if (cand >= NUM_DIGITS) cand = cand - NUM_DIGITS;
            if (!found && digit_en[cand]) begin
                idx_next = IDX_W'(cand);
                found    = 1'b1;
            end
        end
    end

    // Slot visibility and data are frozen at slot start so mid-slot input changes wait.
    assign slot_byte = slot_start ? seg_data[idx_q*SEG_W +: SEG_W] : seg_q;
    assign slot_lit  = slot_start ? (digit_en[idx_q] && !blink_hide) : lit_q;

    always_comb begin
        idx_d    = (slot_end && found) ? idx_next : idx_q;
        tick_d   = slot_end && found && (idx_next <= idx_q);
        seg_d    = slot_byte;
        lit_d    = slot_lit;
        ledsel_d = SEL_NONE;
        ledout_d = SEG_OFF;
        if (slot_lit && phase == PH_ON) begin
            ledsel_d = ~(NUM_DIGITS'(1) << idx_q);
            ledout_d = slot_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            lit_q    <= 1'b0;
            ledsel_q <= SEL_NONE;
            ledout_q <= SEG_OFF;
            tick_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            lit_q    <= lit_d;
            ledsel_q <= ledsel_d;
            ledout_q <= ledout_d;
            tick_q   <= tick_d;
        end
    end

`ifdef LED_MUX_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            bph_q, bph_d;

    always_comb begin
        fcnt_d = fcnt_q;
        bph_d  = bph_q;
        if (tick_d) begin
            if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                fcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fcnt_q <= '0;
            bph_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            bph_q  <= bph_d;
        end
    end

    assign blink_hide = bph_q & blink_mask[idx_q];
`else
    assign blink_hide = 1'b0;
`endif

    assign LEDSEL     = ledsel_q;
    assign LEDOUT     = ledout_q;
    assign frame_tick = tick_q;
    assign cur_digit  = idx_q;

endmodule

// File: tb/tb_led_mux_scan.sv
// tb/tb_led_mux_scan.sv - randomized scoreboard bench for led_mux_scan
module tb_led_mux_scan;

    localparam int NUM_DIGITS   = 4;
    localparam int SEG_W        = 8;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int BRIGHT_W     = 2;
    localparam int BLINK_FRAMES = 2;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       tick;
        logic [1:0] cur;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seg_data;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
`ifdef LED_MUX_SCAN_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [3:0]  LEDSEL;
    logic [7:0]  LEDOUT;
    logic [1:0]  cur_digit;
    logic        frame_tick;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    led_mux_scan #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SEG_W        (SEG_W),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .digit_en   (digit_en),
        .brightness (brightness),
`ifdef LED_MUX_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .LEDSEL     (LEDSEL),
        .LEDOUT     (LEDOUT),
        .cur_digit  (cur_digit),
        .frame_tick (frame_tick)
    );

    // Reference model: position in slot from cycles since reset, slot waveform from the rules.
    int         m_n = 0;
    int         m_idx = 0;
    int         m_on = 0;
    logic [7:0] m_byte = 8'hFF;
    logic       m_lit = 1'b0;
    int         m_frames = 0;
    logic       m_bph = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   pos;
        int   nxt;
        e = '{sel: 4'hF, seg: 8'hFF, tick: 1'b0, cur: 2'd0};
        if (!rst) begin
            m_n = 0; m_idx = 0; m_frames = 0; m_bph = 1'b0; m_lit = 1'b0;
        end else begin
            pos = m_n % SCAN_DIV;
            if (pos == 0) begin
                m_on   = ((SCAN_DIV - BLANK_CYCLES) * (int'(brightness) + 1)) / (1 << BRIGHT_W);
                m_byte = seg_data[m_idx*8 +: 8];
                m_lit  = digit_en[m_idx];
`ifdef LED_MUX_SCAN_BLINK_EN
                if (m_bph && blink_mask[m_idx]) m_lit = 1'b0;
`endif
            end
            if (m_lit && pos >= BLANK_CYCLES && pos < BLANK_CYCLES + m_on) begin
                e.sel = ~(4'b0001 << m_idx);
                e.seg = m_byte;
            end
            if (pos == SCAN_DIV - 1 && digit_en != 4'b0000) begin
                nxt = m_idx;
                for (int k = NUM_DIGITS; k >= 1; k--)
                    if (digit_en[(m_idx + k) % NUM_DIGITS]) nxt = (m_idx + k) % NUM_DIGITS;
                e.tick = (nxt <= m_idx);
                m_idx  = nxt;
                if (e.tick) begin
                    m_frames++;
                    if (m_frames == BLINK_FRAMES) begin
                        m_frames = 0;
                        m_bph    = !m_bph;
                    end
                end
            end
            e.cur = 2'(m_idx);
            m_n++;
        end
        sbq.push_back(e);
    end

    // Monitor: one expected entry per clock edge, compared on the falling edge.
    int   since_rel = 0;
    logic first_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        since_rel = rst ? since_rel + 1 : 0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (LEDSEL !== e.sel || LEDOUT !== e.seg || frame_tick !== e.tick || cur_digit !== e.cur) begin
                errors++;
                $display("FAIL scan t=%0t got sel=%b seg=%h tick=%b cur=%0d required sel=%b seg=%h tick=%b cur=%0d",
                         $time, LEDSEL, LEDOUT, frame_tick, cur_digit, e.sel, e.seg, e.tick, e.cur);
            end
        end
        if (!first_done && since_rel == 4) begin
            first_done = 1'b1;
            checks++;
            if (LEDSEL !== 4'b1110 || LEDOUT !== 8'hC0) begin
                errors++;
                $display("FAIL first_lit got sel=%b seg=%h required sel=1110 seg=c0", LEDSEL, LEDOUT);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst        = 1'b0;
        seg_data   = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
        digit_en   = 4'hF;
        brightness = 2'd3;
`ifdef LED_MUX_SCAN_BLINK_EN
        blink_mask = 4'h0;
`endif
        run(5);
        rst = 1'b1;
        run(96);
        brightness = 2'd1; run(40);
        brightness = 2'd0; run(40);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) brightness = 2'($urandom);
            step();
        end
        brightness = 2'd3;
        digit_en = 4'b1010; run(48);
        digit_en = 4'b0000; run(40);
        digit_en = 4'b1111; run(40);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) seg_data[7:0] = 8'($urandom);
            step();
        end
        for (int r = 0; r < 6; r++) begin
            run($urandom_range(3, 20));
            rst = 1'b0; step(); rst = 1'b1;
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) seg_data = $urandom;
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 40) == 0) digit_en = 4'($urandom);
            rst = ($urandom_range(0, 200) != 0);
            step();
        end
        rst = 1'b1;
`ifdef LED_MUX_SCAN_BLINK_EN
        rst = 1'b0; step(); rst = 1'b1;
        digit_en = 4'hF; brightness = 2'd3; blink_mask = 4'b0001;
        run(200);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 30) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 60) == 0) digit_en = 4'($urandom);
            step();
        end
`endif
        run(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
